vend_credit_controller: RTL and testbench

//   Sequences one vending transaction: collects coins into a credit register,

---
 rtl/vend_credit_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_vend_credit_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_controller.sv
// ---------------------------------------------------------------------------
// vend_credit_controller
//   Runs one vending transaction. Coins build up credit, a product selection
//   is checked against its price, the dispenser is driven via disp_req/ack,
//   and any remaining credit is paid back one unit coin at a time via
//   chg_req/ack.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   coin_n, coin_d  1-cycle coin pulses worth 1 and 2 units
//   sel_a, sel_b    1-cycle product select pulses (A wins if both are high)
//   cancel          1-cycle abort pulse, refunds all credit
//   disp_req/sel    dispense request and product (0=A, 1=B), held until ack
//   disp_ack        dispenser completion, looked at only in DISPENSE
//   chg_req/ack     one-coin change handshake
//   credit          current credit in units
//   coin_reject     registered pulse: coin(s) of that cycle were refused
//   sel_nack        registered pulse: selection refused
//   busy            high while dispensing or returning change
// ---------------------------------------------------------------------------
module vend_credit_controller #(
  parameter int CREDIT_W   = 5,
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 4,
  parameter int MAX_CREDIT = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_n,
  input  logic                coin_d,
  input  logic                sel_a,
  input  logic                sel_b,
  input  logic                cancel,
  output logic                disp_req,
  output logic                disp_sel,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_nack,
  output logic                busy
);

  // The timer only has to reach TIMEOUT-1.
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SUM_W   = CREDIT_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CREDIT_W-1:0] credit_r, credit_s;
  logic                sel_r, sel_s;
  logic [TIMER_W-1:0]  timer_r, timer_s;
  // The timer advances on every second quiet COLLECT cycle; phase_r tracks
  // which half of the pair we are in.
  logic                phase_r, phase_s;
  logic                coin_reject_r, coin_reject_s;
  logic                sel_nack_r, sel_nack_s;

  logic                coin_any_s;
  logic                sel_any_s;
  logic [SUM_W-1:0]    credit_sum_s;
  logic                coin_fits_s;
  logic [CREDIT_W-1:0] price_s;
  logic                price_ok_s;

  // Shared decode of the coin value and the selected price
  always_comb begin
    coin_any_s   = coin_n | coin_d;
    sel_any_s    = sel_a | sel_b;
    // {coin_d, coin_n} is exactly coin_d*2 + coin_n.
    credit_sum_s = {2'b00, credit_r} + {{CREDIT_W{1'b0}}, coin_d, coin_n};
    coin_fits_s  = (credit_sum_s <= SUM_W'(MAX_CREDIT));
    if (sel_a) begin
      price_s = CREDIT_W'(PRICE_A);
    end else begin
      price_s = CREDIT_W'(PRICE_B);
    end
    price_ok_s   = (credit_r >= price_s);
  end

  // Next-state, credit, timer and pulse logic
  always_comb begin
    state_s       = state_r;
    credit_s      = credit_r;
    sel_s         = sel_r;
    timer_s       = timer_r;
    phase_s       = phase_r;
    coin_reject_s = 1'b0;
    sel_nack_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        timer_s = {TIMER_W{1'b0}};
        phase_s = 1'b0;
        if (sel_any_s) begin
          sel_nack_s = 1'b1;
        end else begin
          sel_nack_s = 1'b0;
        end
        if (coin_any_s) begin
          if (coin_fits_s) begin
            credit_s = credit_sum_s[CREDIT_W-1:0];
            state_s  = ST_COLLECT;
          end else begin
            coin_reject_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (cancel) begin
          // A cancel beats any coin or select in the same cycle.
          state_s       = ST_CHANGE;
          coin_reject_s = coin_any_s;
          timer_s       = {TIMER_W{1'b0}};
          phase_s       = 1'b0;
        end else if (sel_any_s && price_ok_s) begin
          state_s       = ST_DISPENSE;
          sel_s         = ~sel_a;
          credit_s      = credit_r - price_s;
          coin_reject_s = coin_any_s;
          timer_s       = {TIMER_W{1'b0}};
          phase_s       = 1'b0;
        end else if (sel_any_s || coin_any_s) begin
          // A refused select does not win, so a coin this cycle still counts.
          timer_s    = {TIMER_W{1'b0}};
          phase_s    = 1'b0;
          sel_nack_s = sel_any_s;
          if (coin_any_s && coin_fits_s) begin
            credit_s = credit_sum_s[CREDIT_W-1:0];
          end else begin
            coin_reject_s = coin_any_s;
          end
        end else if (timer_r == TIMER_W'(TIMEOUT - 1)) begin
          state_s = ST_CHANGE;
          timer_s = {TIMER_W{1'b0}};
          phase_s = 1'b0;
        end else begin
          phase_s = ~phase_r;
          if (phase_r) begin
            timer_s = timer_r + TIMER_W'(1);
          end else begin
            timer_s = timer_r;
          end
        end
      end

      ST_DISPENSE: begin
        coin_reject_s = coin_any_s;
        if (disp_ack) begin
          if (credit_r != {CREDIT_W{1'b0}}) begin
            state_s = ST_CHANGE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DISPENSE;
        end
      end

      ST_CHANGE: begin
        coin_reject_s = coin_any_s;
        if (chg_ack && (credit_r != {CREDIT_W{1'b0}})) begin
          credit_s = credit_r - CREDIT_W'(1);
          if (credit_r == CREDIT_W'(1)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_CHANGE;
          end
        end else begin
          state_s = ST_CHANGE;
        end
      end

      default: begin
        state_s  = ST_IDLE;
        credit_s = {CREDIT_W{1'b0}};
        sel_s    = 1'b0;
        timer_s  = {TIMER_W{1'b0}};
        phase_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      credit_r      <= {CREDIT_W{1'b0}};
      sel_r         <= 1'b0;
      timer_r       <= {TIMER_W{1'b0}};
      phase_r       <= 1'b0;
      coin_reject_r <= 1'b0;
      sel_nack_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      credit_r      <= credit_s;
      sel_r         <= sel_s;
      timer_r       <= timer_s;
      phase_r       <= phase_s;
      coin_reject_r <= coin_reject_s;
      sel_nack_r    <= sel_nack_s;
    end
  end

  // Moore outputs decoded from registered state
  always_comb begin
    disp_req    = (state_r == ST_DISPENSE);
    disp_sel    = (state_r == ST_DISPENSE) & sel_r;
    chg_req     = (state_r == ST_CHANGE) & (credit_r != {CREDIT_W{1'b0}});
    busy        = (state_r == ST_DISPENSE) | (state_r == ST_CHANGE);
    credit      = credit_r;
    coin_reject = coin_reject_r;
    sel_nack    = sel_nack_r;
  end

endmodule

// File: tb/tb_vend_credit_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_controller
//   Directed transaction scenarios followed by random traffic, each cycle
//   compared against a transaction-level reference model kept in the bench.
// ---------------------------------------------------------------------------
module tb_vend_credit_controller;

  localparam int CW  = 5;
  localparam int PA  = 3;
  localparam int PB  = 4;
  localparam int MAX = 10;
  localparam int TO  = 255;

  localparam int M_IDLE = 0, M_COLLECT = 1, M_DISPENSE = 2, M_CHANGE = 3;

  logic          clk, rst;
  logic          coin_n, coin_d, sel_a, sel_b, cancel;
  logic          disp_req, disp_sel, disp_ack, chg_req, chg_ack;
  logic [CW-1:0] credit;
  logic          coin_reject, sel_nack, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model
  int   m_mode, m_credit, m_sel, m_quiet;
  logic m_rej, m_nack;

  vend_credit_controller #(
    .CREDIT_W(CW), .PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MAX), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .coin_n(coin_n), .coin_d(coin_d), .sel_a(sel_a),
    .sel_b(sel_b), .cancel(cancel), .disp_req(disp_req), .disp_sel(disp_sel),
    .disp_ack(disp_ack), .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit),
    .coin_reject(coin_reject), .sel_nack(sel_nack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction rules applied to one cycle of inputs.
  task automatic model_step(input bit cn, cd, sa, sb, cx, da, ca, r);
    int v, price;
    bit sel;
    v     = (cn ? 1 : 0) + (cd ? 2 : 0);
    sel   = sa | sb;
    price = sa ? PA : PB;
    m_rej  = 1'b0;
    m_nack = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_credit = 0; m_sel = 0; m_quiet = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_nack = sel;
          if (v > 0) begin
            if (m_credit + v <= MAX) begin
              m_credit += v; m_mode = M_COLLECT; m_quiet = 0;
            end else m_rej = 1'b1;
          end
        end
        M_COLLECT: begin
          if (cx) begin
            m_mode = M_CHANGE; m_rej = (v > 0);
          end else if (sel && m_credit >= price) begin
            m_mode = M_DISPENSE; m_credit -= price; m_sel = sa ? 0 : 1;
            m_rej = (v > 0);
          end else if (sel || v > 0) begin
            m_quiet = 0;
            m_nack  = sel;
            if (v > 0) begin
              if (m_credit + v <= MAX) m_credit += v;
              else m_rej = 1'b1;
            end
          end else if (m_quiet == 2 * (TO - 1)) begin
            // timer counts every other quiet cycle up to TIMEOUT-1
            m_mode = M_CHANGE;
          end else begin
            m_quiet++;
          end
        end
        M_DISPENSE: begin
          m_rej = (v > 0);
          if (da) m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
        end
        M_CHANGE: begin
          m_rej = (v > 0);
          if (ca && m_credit > 0) begin
            m_credit--;
            if (m_credit == 0) m_mode = M_IDLE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check("credit", 32'(credit), 32'(m_credit));
    check("disp_req", 32'(disp_req), 32'(m_mode == M_DISPENSE));
    if (m_mode == M_DISPENSE) check("disp_sel", 32'(disp_sel), 32'(m_sel));
    check("chg_req", 32'(chg_req), 32'(m_mode == M_CHANGE && m_credit > 0));
    check("busy", 32'(busy), 32'(m_mode == M_DISPENSE || m_mode == M_CHANGE));
    check("coin_reject", 32'(coin_reject), 32'(m_rej));
    check("sel_nack", 32'(sel_nack), 32'(m_nack));
  endtask

  // One clock cycle: drive, update model, sample 1ns after the edge.
  task automatic step(input bit cn, cd, sa, sb, cx, da, ca, r);
    coin_n = cn; coin_d = cd; sel_a = sa; sel_b = sb; cancel = cx;
    disp_ack = da; chg_ack = ca; rst = r;
    model_step(cn, cd, sa, sb, cx, da, ca, r);
    @(posedge clk);
    #1;
    coin_n = 1'b0; coin_d = 1'b0; sel_a = 1'b0; sel_b = 1'b0; cancel = 1'b0;
    disp_ack = 1'b0; chg_ack = 1'b0; rst = 1'b0;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!chg_req) break;
      step(0, 0, 0, 0, 0, 0, 1, 0);
    end
    check({tag, "_drained_credit"}, 32'(credit), 32'd0);
    check({tag, "_drained_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    coin_n = 1'b0; coin_d = 1'b0; sel_a = 1'b0; sel_b = 1'b0; cancel = 1'b0;
    disp_ack = 1'b0; chg_ack = 1'b0; rst = 1'b1;
    m_mode = M_IDLE; m_credit = 0; m_sel = 0; m_quiet = 0; m_rej = 0; m_nack = 0;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_disp_sel", 32'(disp_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // T1 exact payment
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("t1_credit2", 32'(credit), 32'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("t1_credit3", 32'(credit), 32'd3);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check("t1_disp_req", 32'(disp_req), 32'd1);
    check("t1_disp_sel", 32'(disp_sel), 32'd0);
    check("t1_credit0", 32'(credit), 32'd0);
    idle();
    idle();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("t1_done_busy", 32'(busy), 32'd0);
    check("t1_no_chg", 32'(chg_req), 32'd0);

    // T2 change return
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
    check("t2_credit6", 32'(credit), 32'd6);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check("t2_disp_sel", 32'(disp_sel), 32'd1);
    check("t2_credit2", 32'(credit), 32'd2);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("t2_chg_req", 32'(chg_req), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("t2_credit1", 32'(credit), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("t2_credit0", 32'(credit), 32'd0);
    check("t2_chg_low", 32'(chg_req), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);

    // T3 overflow with both coins in one cycle
    repeat (4) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("t3_credit9", 32'(credit), 32'd9);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("t3_reject", 32'(coin_reject), 32'd1);
    check("t3_credit_held", 32'(credit), 32'd9);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("t3_credit10", 32'(credit), 32'd10);
    check("t3_no_reject", 32'(coin_reject), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    drain("t3");

    // T4 cancel beats select beats coin
    repeat (2) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0);
    check("t4_chg_req", 32'(chg_req), 32'd1);
    check("t4_no_disp", 32'(disp_req), 32'd0);
    check("t4_reject", 32'(coin_reject), 32'd1);
    check("t4_credit4", 32'(credit), 32'd4);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!chg_req) break;
      step(0, 0, 0, 0, 0, 0, 1, 0);
      n++;
    end
    check("t4_refund_units", 32'(n), 32'd4);

    // T5 refused select, then inactivity timeout
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check("t5_nack", 32'(sel_nack), 32'd1);
    check("t5_credit2", 32'(credit), 32'd2);
    check("t5_not_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 2 * TO + 20; i++) begin
      idle();
      n++;
      if (busy) break;
    end
    check("t5_timeout_cycles", 32'(n), 32'(2 * (TO - 1) + 1));
    check("t5_chg_req", 32'(chg_req), 32'd1);
    drain("t5");

    // T6 reset while dispensing
    repeat (2) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check("t6_disp_req", 32'(disp_req), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("t6_rst_disp", 32'(disp_req), 32'd0);
    check("t6_rst_credit", 32'(credit), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("t6_ack_ignored", 32'(busy), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(5) == 0, $urandom_range(5) == 0,
           $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(40) == 0, $urandom_range(2) == 0,
           $urandom_range(2) == 0, $urandom_range(300) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
